// File: rtl/stream_demux_if.sv
// Handshake bundle for the 1-to-2 stream demultiplexer: one producer stream in, two consumer streams out.
interface stream_demux_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [CW-1:0]    out0_count;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    out1_count;

  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_count,
           out1_valid, out1_data, out1_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_count,
           out1_valid, out1_data, out1_count
  );
endinterface

// File: rtl/stream_demux.sv
// Steers one valid/ready word stream into one of two independent per-channel FIFOs.
// A stalled consumer only backpressures words addressed to its own channel.
module stream_demux #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  stream_demux_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    wr_ptr_d [2];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [PW-1:0]    rd_ptr_d [2];
  logic [CW-1:0]    count_q  [2];
  logic [CW-1:0]    count_d  [2];
  logic [WIDTH-1:0] mem_q    [2][DEPTH];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;
  logic       in_ready;

  // in_ready looks only at registered occupancy, so a same-cycle pop never frees a full slot
  always_comb begin
    out_ready = {bus.out1_ready, bus.out0_ready};
    full      = '0;
    empty     = '0;
    push      = '0;
    pop       = '0;
    for (int n = 0; n < 2; n++) begin
      full[n]  = (count_q[n] == CW'(DEPTH));
      empty[n] = (count_q[n] == '0);
    end
    in_ready = !full[bus.in_sel];
    for (int n = 0; n < 2; n++) begin
      push[n] = bus.in_valid && in_ready && (bus.in_sel == 1'(n));
      pop[n]  = !empty[n] && out_ready[n];
    end
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      wr_ptr_d[n] = wr_ptr_q[n];
      rd_ptr_d[n] = rd_ptr_q[n];
      count_d[n]  = count_q[n];
      if (push[n]) begin
        wr_ptr_d[n] = wr_ptr_q[n] + PW'(1);
      end
      if (pop[n]) begin
        rd_ptr_d[n] = rd_ptr_q[n] + PW'(1);
      end
      case ({push[n], pop[n]})
        2'b10:   count_d[n] = count_q[n] + CW'(1);
        2'b01:   count_d[n] = count_q[n] - CW'(1);
        default: count_d[n] = count_q[n];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        count_q[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
        count_q[n]  <= count_d[n];
      end
    end
  end

  // Storage is left uncleared on reset; empty channels mask their head word to zero instead
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n] && !reset) begin
        mem_q[n][wr_ptr_q[n]] <= bus.in_data;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = !empty[0];
  assign bus.out0_data  = empty[0] ? '0 : mem_q[0][rd_ptr_q[0]];
  assign bus.out0_count = count_q[0];
  assign bus.out1_valid = !empty[1];
  assign bus.out1_data  = empty[1] ? '0 : mem_q[1][rd_ptr_q[1]];
  assign bus.out1_count = count_q[1];
endmodule
